mem_controller: RTL
===================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU request ports arbitrated.
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-006 SHALL have port consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request.
REQ-007 SHALL have port consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses; consumer i at slice [i*ADDR_BITS +: ADDR_BITS].
REQ-008 SHALL have port consumer_read_ready  out  NUM_CONSUMERS  per-LSU read completion.
REQ-009 SHALL have port consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed returned read data.
REQ-010 SHALL have port consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request.
REQ-011 SHALL have port consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
REQ-012 SHALL have port consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data.
REQ-013 SHALL have port consumer_write_ready  out  NUM_CONSUMERS  per-LSU write completion.
REQ-014 SHALL have ports mem_read_valid out 1, mem_read_address out ADDR_BITS, mem_read_ready in 1, mem_read_data in DATA_BITS: single memory read channel.
REQ-015 SHALL have ports mem_write_valid out 1, mem_write_address out ADDR_BITS, mem_write_data out DATA_BITS, mem_write_ready in 1: single memory write channel.

Function
REQ-016 SHALL register every output; no combinational path from any input to any output.
REQ-017 SHALL implement states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING; exactly one transaction in flight at a time.
REQ-018 IDLE: scan consumers round-robin from pointer rr (reset 0); first consumer i with read_valid or write_valid wins; read beats write when both set on the same consumer.
REQ-019 IDLE grant to read: latch i, mem_read_valid<=1, mem_read_address<=consumer i address, -> READ_WAITING; write grant analogous with mem_write_valid/address/data, -> WRITE_WAITING.
REQ-020 IDLE with no valid request: remain IDLE, all valid/ready outputs 0.
REQ-021 READ_WAITING: hold mem_read_valid/address stable until mem_read_ready==1; then mem_read_valid<=0, consumer_read_data slice i<=mem_read_data, consumer_read_ready[i]<=1, -> READ_RELAYING.
REQ-022 WRITE_WAITING: hold mem_write_* stable until mem_write_ready==1; then mem_write_valid<=0, consumer_write_ready[i]<=1, -> WRITE_RELAYING.
REQ-023 RELAYING: hold ready[i] at 1 until consumer i's matching valid samples 0; that edge ready[i]<=0, rr<=(i+1) mod NUM_CONSUMERS, -> IDLE.
REQ-024 Minimum latency: consumer valid sampled at edge 0 -> mem valid high after edge 0; mem ready sampled at edge k -> consumer ready high after edge k; next grant no earlier than the edge after valid drops.
REQ-025 rr SHALL wrap from NUM_CONSUMERS-1 to 0; a continuously requesting consumer cannot be granted twice while another consumer requests.
REQ-026 Consumer dropping valid during WAITING: memory transaction still completes, ready[i] pulses for exactly one cycle, then IDLE.
REQ-027 consumer_read_data slices SHALL hold their last value until overwritten by a later read to the same consumer.
REQ-028 mem_read_ready/mem_write_ready asserted outside the matching WAITING state SHALL be ignored.

Reset
REQ-029 reset==0 SHALL immediately, without clock, force state IDLE, rr=0, and all outputs (valids, readies, addresses, data) to 0, including mid-transaction.
REQ-030 After reset release, first grant SHALL occur on the first rising edge with a request present.

Verification
REQ-031 Single read: consumer 2 read addr 0x15, memory returns 0xA7 after 3 cycles -> mem_read_address=0x15, consumer_read_data[2]=0xA7, consumer_read_ready[2] high until valid drops.
REQ-032 Single write: consumer 0 write addr 0x40 data 0x3C -> mem_write_address=0x40, mem_write_data=0x3C, consumer_write_ready[0] asserted after mem_write_ready.
REQ-033 Contention: all 4 consumers read simultaneously, rr=0 -> grant order 0,1,2,3; consumer 0 re-requests immediately -> served after 3.
REQ-034 Wrap: rr=3, consumers 3 and 1 request -> 3 then 1; rr ends at 2.
REQ-035 Same consumer read+write valid together -> read serviced first, write next grant.
REQ-036 Reset asserted in READ_WAITING -> mem_read_valid and all readies 0 before next edge; clean read after release.

Source files
------------

// File: rtl/mem_controller.sv
// -----------------------------------------------------------------------------
// mem_controller
//
// Arbitrates NUM_CONSUMERS load/store units onto one memory read channel and
// one memory write channel, with a single transaction in flight at a time.
// Consumers are scanned round-robin from pointer rr. The granted request is
// forwarded to memory, and the result is relayed back. The consumer's ready
// stays high until that consumer drops its valid.
//
// Ports:
//   clk, reset                    clock and asynchronous active-low reset
//   consumer_read_valid/address   per-consumer read requests (packed)
//   consumer_read_ready/data      per-consumer read completion and data
//   consumer_write_valid/address/data  per-consumer write requests (packed)
//   consumer_write_ready          per-consumer write completion
//   mem_read_*                    memory read channel (valid/address out, ready/data in)
//   mem_write_*                   memory write channel (valid/address/data out, ready in)
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                           state, state_next;
  logic [IDX_BITS-1:0]              rr, rr_next;
  logic [IDX_BITS-1:0]              cur, cur_next;
  logic [IDX_BITS-1:0]              cur_plus_one;
  logic [NUM_CONSUMERS-1:0]         consumer_read_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_next;
  logic [NUM_CONSUMERS-1:0]         consumer_write_ready_next;
  logic                             mem_read_valid_next;
  logic [ADDR_BITS-1:0]             mem_read_address_next;
  logic                             mem_write_valid_next;
  logic [ADDR_BITS-1:0]             mem_write_address_next;
  logic [DATA_BITS-1:0]             mem_write_data_next;

  // Round-robin scan results
  logic                             found;
  logic                             grant_read;
  logic [IDX_BITS-1:0]              grant_idx;
  logic [IDX_BITS-1:0]              scan_idx;
  int                               scan_pos;

  // State register plus every output register. Reset is asynchronous and
  // clears everything, including an in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      rr                   <= '0;
      cur                  <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state                <= state_next;
      rr                   <= rr_next;
      cur                  <= cur_next;
      consumer_read_ready  <= consumer_read_ready_next;
      consumer_read_data   <= consumer_read_data_next;
      consumer_write_ready <= consumer_write_ready_next;
      mem_read_valid       <= mem_read_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
    end
  end

  // Wrapping successor of the current consumer. It becomes the new rr once
  // a transaction retires, so the same consumer cannot win twice in a row
  // while another consumer is requesting.
  assign cur_plus_one = (int'(cur) == NUM_CONSUMERS - 1) ? '0 : cur + 1'b1;

  // Round-robin scan starting at rr. The first consumer with any request
  // wins. Read takes priority over write on the same consumer.
  always_comb begin
    found      = 1'b0;
    grant_read = 1'b0;
    grant_idx  = '0;
    scan_idx   = '0;
    scan_pos   = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_pos = int'(rr) + k;
      if (scan_pos >= NUM_CONSUMERS) scan_pos = scan_pos - NUM_CONSUMERS;
      scan_idx = IDX_BITS'(scan_pos);
      if (!found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        found      = 1'b1;
        grant_idx  = scan_idx;
        grant_read = consumer_read_valid[scan_idx];
      end
    end
  end

  // Next-state and next-output logic. Every register holds its value by
  // default, so the mem_* outputs stay stable while waiting. The read-data
  // slices keep their last value until a later read to the same consumer.
  always_comb begin
    state_next                = state;
    rr_next                   = rr;
    cur_next                  = cur;
    consumer_read_ready_next  = consumer_read_ready;
    consumer_read_data_next   = consumer_read_data;
    consumer_write_ready_next = consumer_write_ready;
    mem_read_valid_next       = mem_read_valid;
    mem_read_address_next     = mem_read_address;
    mem_write_valid_next      = mem_write_valid;
    mem_write_address_next    = mem_write_address;
    mem_write_data_next       = mem_write_data;

    case (state)
      IDLE: begin
        if (found) begin
          cur_next = grant_idx;
          if (grant_read) begin
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
            state_next            = READ_WAITING;
          end else begin
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
            mem_write_data_next    = consumer_write_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
            state_next             = WRITE_WAITING;
          end
        end
      end

      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_next                                      = 1'b0;
          consumer_read_data_next[int'(cur)*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_next[cur]                            = 1'b1;
          state_next                                               = READ_RELAYING;
        end
      end

      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_next           = 1'b0;
          consumer_write_ready_next[cur] = 1'b1;
          state_next                     = WRITE_RELAYING;
        end
      end

      // A consumer that already dropped valid while waiting sees ready
      // for exactly one cycle, because valid is found low on the first
      // relaying edge.
      READ_RELAYING: begin
        if (!consumer_read_valid[cur]) begin
          consumer_read_ready_next[cur] = 1'b0;
          rr_next                       = cur_plus_one;
          state_next                    = IDLE;
        end
      end

      WRITE_RELAYING: begin
        if (!consumer_write_valid[cur]) begin
          consumer_write_ready_next[cur] = 1'b0;
          rr_next                        = cur_plus_one;
          state_next                     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
